// File: rtl/instruction_sequencer_pkg.sv
// rtl/instruction_sequencer_pkg.sv - control word, sequencer state and select encodings
package instruction_sequencer_pkg;

  typedef enum logic [1:0] {
    ALU_Result             = 2'd0,
    Memory                 = 2'd1,
    Program_Counter_Plus_4 = 2'd2
  } register_write_data_source_t;

  typedef struct packed {
    logic                        register_write_enable;
    register_write_data_source_t register_write_data_source;
    logic                        memory_write_enable;
    logic                        branch;
  } control_t;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, FAULT
  } sequencer_state_t;

  localparam logic Program_Counter_Plus_4_Select = 1'b0;
  localparam logic ALU_Result_Select             = 1'b1;

  function automatic logic is_memory_access(control_t c);
    return (c.register_write_data_source == Memory) || c.memory_write_enable;
  endfunction

endpackage

// File: rtl/instruction_sequencer_timeout.sv
// rtl/instruction_sequencer_timeout.sv - memory_timeout_counter: wait-cycle counter for one memory access
module memory_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 200,
  parameter int unsigned TIMEOUT_WIDTH  = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam logic [TIMEOUT_WIDTH-1:0] LAST_COUNT =
    (TIMEOUT_CYCLES == 0) ? '0 : TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)      count_d = '0;
    else if (count) count_d = count_q + TIMEOUT_WIDTH'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // A zero TIMEOUT_CYCLES disables faulting entirely.
  assign expired = (TIMEOUT_CYCLES != 0) && (count_q == LAST_COUNT);

endmodule

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - multi-cycle fetch/decode/execute/memory/writeback sequencer
// Optional single-step input enabled by SEQUENCER_SINGLE_STEP_EN.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 200,
  parameter int unsigned TIMEOUT_WIDTH  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run_enable,
`ifdef SEQUENCER_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  control_t         control,
  input  logic             illegal_instruction,
  input  logic             branch_taken,
  input  logic             memory_ready,
  output logic             memory_request,
  output logic             memory_write,
  output logic             memory_address_source,
  output logic             instruction_register_write_enable,
  output logic             program_counter_write_enable,
  output logic             program_counter_source,
  output logic             register_write_enable,
  output logic             retired,
  output logic             halted,
  output sequencer_state_t state
);

  sequencer_state_t state_q, state_d;
  logic timeout_expired, timeout_clear, timeout_count;
  logic start_instruction, continue_run;

`ifdef SEQUENCER_SINGLE_STEP_EN
  logic step_mode_q;

  assign start_instruction = run_enable | step;
  assign continue_run      = run_enable & ~step_mode_q;

  // Remembers that the instruction in flight was launched by a step pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                step_mode_q <= 1'b0;
    else if (state_q == IDLE) step_mode_q <= ~run_enable & step;
  end
`else
  assign start_instruction = run_enable;
  assign continue_run      = run_enable;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_instruction) state_d = FETCH;
      FETCH:     if (memory_ready) state_d = DECODE;
                 else if (timeout_expired) state_d = FAULT;
      DECODE:    state_d = illegal_instruction ? FAULT : EXECUTE;
      EXECUTE:   state_d = is_memory_access(control) ? MEMORY : WRITEBACK;
      MEMORY:    if (memory_ready) state_d = WRITEBACK;
                 else if (timeout_expired) state_d = FAULT;
      WRITEBACK: state_d = continue_run ? FETCH : IDLE;
      FAULT:     state_d = FAULT;
      default:   state_d = FAULT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign timeout_clear = ((state_d == FETCH) || (state_d == MEMORY)) && (state_d != state_q);
  assign timeout_count = ((state_q == FETCH) || (state_q == MEMORY)) && !memory_ready;

  memory_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (timeout_clear),
    .count  (timeout_count),
    .expired(timeout_expired)
  );

  always_comb begin
    memory_request                    = 1'b0;
    memory_write                      = 1'b0;
    memory_address_source             = 1'b0;
    instruction_register_write_enable = 1'b0;
    program_counter_write_enable      = 1'b0;
    program_counter_source            = Program_Counter_Plus_4_Select;
    register_write_enable             = 1'b0;
    retired                           = 1'b0;
    halted                            = 1'b0;
    case (state_q)
      FETCH: begin
        memory_request                    = 1'b1;
        instruction_register_write_enable = memory_ready;
      end
      MEMORY: begin
        memory_request        = 1'b1;
        memory_address_source = 1'b1;
        memory_write          = control.memory_write_enable;
      end
      WRITEBACK: begin
        register_write_enable        = control.register_write_enable;
        program_counter_write_enable = 1'b1;
        program_counter_source       = (control.branch & branch_taken) ?
                                       ALU_Result_Select : Program_Counter_Plus_4_Select;
        retired                      = 1'b1;
      end
      FAULT:   halted = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule
